// File: rtl/str_arb_if.sv
// rtl/str_arb_if.sv - stream bundle between N sources, the arbiter and one sink
interface str_arb_if #(
  parameter int N  = 4,
  parameter int VW = 32,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N*VW-1:0] s_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [VW-1:0]   m_tdata;
  logic [IW-1:0]   m_tid;

  // master: the arbiter side; slave: the sources plus the sink
  modport master (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tid
  );

  modport slave (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tid
  );
endinterface

// File: rtl/str_arb.sv
// rtl/str_arb.sv - round-robin N:1 stream arbiter with burst limit and registered output
module str_arb #(
  parameter int N  = 4,
  parameter int VW = 32,
  parameter int BL = 1,
  parameter int IW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  str_arb_if.master  bus
);
  localparam int            CW       = $clog2(BL + 1);
  localparam logic [CW-1:0] BLC      = CW'(BL);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  logic [IW-1:0] last;
  logic [CW-1:0] cnt;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          found;
  logic          burst;
  logic          ld;
  logic          acc;
  logic [N-1:0]  rdy;
  logic [VW-1:0] sel_data;

  logic          tvalid_q;
  logic [VW-1:0] tdata_q;
  logic [IW-1:0] tid_q;

  assign ld    = ~tvalid_q | bus.m_tready;
  assign burst = bus.s_tvalid[last] && (cnt != '0) && (cnt < BLC);
  assign acc   = found & ld & ~rst;

  // Burst continuation keeps the owner; otherwise scan from last+1, wrapping onto last itself.
  always_comb begin
    found = 1'b0;
    sel   = last;
    idx   = '0;
    if (burst) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = IW'((int'(last) + k) % N);
        if (!found && bus.s_tvalid[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  always_comb begin
    rdy      = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_data = bus.s_tdata[i*VW +: VW];
        rdy[i]   = acc;
      end
    end
  end

  assign bus.s_tready = rdy;
  assign bus.m_tvalid = tvalid_q;
  assign bus.m_tdata  = tdata_q;
  assign bus.m_tid    = tid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
      last     <= LAST_RST;
      cnt      <= '0;
    end else if (ld) begin
      tvalid_q <= acc;
      if (acc) begin
        tdata_q <= sel_data;
        tid_q   <= sel;
        last    <= sel;
        // A wrap back to the owner after hitting the limit starts a fresh run.
        cnt     <= burst ? cnt + 1'b1 : CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_str_arb.sv
// tb/tb_str_arb.sv - random and directed bench for str_arb at BL=1 and BL=2
module tb_str_arb;
  localparam int N  = 4;
  localparam int VW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  str_arb_if #(.N(N), .VW(VW), .IW(IW)) b1();
  str_arb_if #(.N(N), .VW(VW), .IW(IW)) b2();

  str_arb #(.N(N), .VW(VW), .BL(1), .IW(IW)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  str_arb #(.N(N), .VW(VW), .BL(2), .IW(IW)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int total = 0;
  int bad   = 0;

  // Reference state per instance (index 0: BL=1, index 1: BL=2)
  bit            pend [2][N];
  logic [VW-1:0] pdat [2][N];
  bit            ov   [2];
  logic [VW-1:0] od   [2];
  int            oid  [2];
  int            m_last [2];
  int            m_cnt  [2];
  int            hid  [2][256];
  logic [VW-1:0] hd   [2][256];
  int            hn   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int u);
    int bl = u + 1;
    int l  = m_last[u];
    if (pend[u][l] && m_cnt[u] > 0 && m_cnt[u] < bl) return l;
    for (int k = 1; k <= N; k++)
      if (pend[u][(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction

  task automatic drive(input bit rdy);
    logic [N-1:0]    v;
    logic [N*VW-1:0] d;
    for (int u = 0; u < 2; u++) begin
      v = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
        v[i] = pend[u][i];
        d[i*VW +: VW] = pdat[u][i];
      end
      if (u == 0) begin
        b1.s_tvalid = v; b1.s_tdata = d; b1.m_tready = rdy;
      end else begin
        b2.s_tvalid = v; b2.s_tdata = d; b2.m_tready = rdy;
      end
    end
  endtask

  task automatic check_outputs();
    chk("bl1_m_tvalid", 64'(b1.m_tvalid), 64'(ov[0]));
    chk("bl1_m_tdata",  64'(b1.m_tdata),  64'(od[0]));
    chk("bl1_m_tid",    64'(b1.m_tid),    64'(oid[0]));
    chk("bl2_m_tvalid", 64'(b2.m_tvalid), 64'(ov[1]));
    chk("bl2_m_tdata",  64'(b2.m_tdata),  64'(od[1]));
    chk("bl2_m_tid",    64'(b2.m_tid),    64'(oid[1]));
  endtask

  // One clock: called on a negedge, returns on the next negedge.
  task automatic step(input logic [N-1:0] want, input bit rdy, input logic [N*VW-1:0] dat);
    logic [N-1:0] one;
    logic [N-1:0] exp_rdy;
    int s;
    bit ldv;
    one = 1;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < N; i++)
        if (want[i] && !pend[u][i]) begin
          pend[u][i] = 1'b1;
          pdat[u][i] = dat[i*VW +: VW];
        end
    drive(rdy);
    #1;
    for (int u = 0; u < 2; u++) begin
      ldv = !ov[u] || rdy;
      s   = pick(u);
      exp_rdy = (ldv && s >= 0) ? (one << s) : '0;
      chk(u == 0 ? "bl1_s_tready" : "bl2_s_tready",
          64'(u == 0 ? b1.s_tready : b2.s_tready), 64'(exp_rdy));
      if (ov[u] && rdy) begin
        hid[u][hn[u]] = oid[u];
        hd[u][hn[u]]  = od[u];
        if (hn[u] < 255) hn[u]++;
      end
      if (ldv) begin
        ov[u] = (s >= 0);
        if (s >= 0) begin
          od[u]  = pdat[u][s];
          oid[u] = s;
          m_cnt[u] = (s == m_last[u] && m_cnt[u] > 0 && m_cnt[u] < u + 1) ? m_cnt[u] + 1 : 1;
          m_last[u] = s;
          pend[u][s] = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input bit rdy);
    rst = 1'b1;
    drive(rdy);
    #1;
    chk("rst_s_tready_bl1", 64'(b1.s_tready), 64'(0));
    chk("rst_s_tready_bl2", 64'(b2.s_tready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      ov[u] = 1'b0; od[u] = '0; oid[u] = 0;
      m_last[u] = N - 1; m_cnt[u] = 0;
      hn[u] = 0;
    end
    check_outputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) step('0, 1'b1, '0);
  endtask

  logic [N*VW-1:0] dat;
  logic [N*VW-1:0] rnd;

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < N; i++) begin
        pend[u][i] = 1'b0;
        pdat[u][i] = '0;
      end
    rst = 1'b1;
    @(negedge clk);
    do_reset(1'b0);

    // Reset priority and pure round-robin
    for (int i = 0; i < N; i++) dat[i*VW +: VW] = 32'h0A0 + i;
    for (int k = 0; k < 8; k++) step(4'b1111, 1'b1, dat);
    for (int k = 0; k < 4; k++) begin
      chk("rr_tid",  64'(hid[0][k]), 64'(k));
      chk("rr_data", 64'(hd[0][k]),  64'(32'h0A0 + k));
    end
    drain();

    // Burst of two between sources 1 and 3
    do_reset(1'b1);
    for (int k = 0; k < 9; k++) step(4'b1010, 1'b1, dat);
    for (int k = 0; k < 8; k++) begin
      chk("burst_tid_bl2", 64'(hid[1][k]), 64'((k % 4) < 2 ? 1 : 3));
      chk("burst_tid_bl1", 64'(hid[0][k]), 64'((k % 2) == 0 ? 1 : 3));
    end
    drain();

    // Single requester keeps full rate under the burst limit
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) step(4'b0100, 1'b1, dat);
    chk("single_count", 64'(hn[1]), 64'(7));
    for (int k = 0; k < 7; k++) chk("single_tid", 64'(hid[1][k]), 64'(2));
    drain();

    // Backpressure 1,0,0,1
    do_reset(1'b1);
    step(4'b0101, 1'b1, dat);
    step(4'b0101, 1'b0, dat);
    chk("bp_stall_rdy", 64'(b1.s_tready), 64'(0));
    step(4'b0101, 1'b0, dat);
    step(4'b0101, 1'b1, dat);
    drain();
    chk("bp_order0", 64'(hid[0][0]), 64'(0));
    chk("bp_order1", 64'(hid[0][1]), 64'(2));
    chk("bp_order2", 64'(hid[0][2]), 64'(0));

    // Sparse single beat
    do_reset(1'b1);
    dat = '0;
    dat[3*VW +: VW] = 32'hDEAD;
    step(4'b1000, 1'b1, dat);
    for (int k = 0; k < 3; k++) step('0, 1'b1, '0);
    chk("sparse_count", 64'(hn[0]), 64'(1));
    chk("sparse_tid",   64'(hid[0][0]), 64'(3));
    chk("sparse_data",  64'(hd[0][0]),  64'(32'hDEAD));

    // Reset while a beat is stalled in the output register
    drain();
    do_reset(1'b1);
    step(4'b1100, 1'b0, dat);
    step(4'b1100, 1'b0, dat);
    do_reset(1'b0);
    chk("rst_mid_valid", 64'(b1.m_tvalid), 64'(0));
    for (int k = 0; k < 4; k++) step(4'b1100, 1'b1, dat);
    chk("rst_first_bl1", 64'(hid[0][0]), 64'(2));
    chk("rst_first_bl2", 64'(hid[1][0]), 64'(2));
    drain();

    // Random traffic
    do_reset(1'b1);
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) rnd[i*VW +: VW] = $urandom;
      step(N'($urandom), ($urandom_range(0, 3) != 0), rnd);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
